// File: rtl/agp32_mem_pkg.sv
// rtl/agp32_mem_pkg.sv - shared types and constants for the agp32 memory controller
// Command, error and state encodings plus the byte-strobe merge helper.
package agp32_mem_pkg;

   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_FETCH = 3'd1,
      CMD_READ  = 3'd2,
      CMD_WRITE = 3'd3,
      CMD_IRQ   = 3'd4
   } mem_cmd_e;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_DATA_OOR  = 2'd1,
      ERR_FETCH_OOR = 2'd2,
      ERR_BAD_CMD   = 2'd3
   } mem_err_e;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      BUSY = 2'd2,
      DONE = 2'd3
   } mem_state_e;

   localparam logic [31:0] NOP_INSTR = 32'd63;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/agp32_wordram.sv
// rtl/agp32_wordram.sv - word-addressed RAM, one byte-strobed write port, two async read ports
// No reset: contents survive rst and are only changed through the write port.
module agp32_wordram
   import agp32_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    wstrb,
   input  logic [AW-1:0] fetch_addr,
   output logic [31:0]   fetch_rdata,
   input  logic [AW-1:0] data_addr,
   output logic [31:0]   data_rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= byte_merge(mem[waddr], wdata, wstrb);
   end

   assign fetch_rdata = mem[fetch_addr];
   assign data_rdata  = mem[data_addr];

endmodule

// File: rtl/agp32_mem_ctrl.sv
// rtl/agp32_mem_ctrl.sv - fixed-latency memory controller behind agp32_processor
// Optional AGP32_MEM_CTRL_INIT_CLEAR_EN: INIT zeroes every RAM word instead of waiting INIT_CYCLES.
module agp32_mem_ctrl
   import agp32_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2,
   parameter int INIT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  command,
   input  logic [31:0] PC,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_wstrb,
   output logic        ready,
   output logic [31:0] inst_rdata,
   output logic [31:0] data_rdata,
   output logic        mem_start_ready,
   output logic [1:0]  error
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
`ifdef AGP32_MEM_CTRL_INIT_CLEAR_EN
   localparam int INIT_LEN = DEPTH_WORDS;
`else
   localparam int INIT_LEN = INIT_CYCLES;
`endif
   localparam int CW = $clog2(INIT_LEN + 1);

   mem_state_e  state;
   logic [CW-1:0] init_cnt;
   logic [3:0]  lat_cnt;
   logic [2:0]  cmd_q;
   logic [31:0] pc_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;

   logic          pc_oor;
   logic          data_oor;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [31:0]   ram_wdata;
   logic [3:0]    ram_wstrb;
   logic [31:0]   ram_fetch;
   logic [31:0]   ram_data;
   logic [1:0]    done_err;

   assign pc_oor   = (pc_q >= ADDR_LIMIT);
   assign data_oor = (addr_q >= ADDR_LIMIT);

   // The write is gated on state, so an async rst leaving DONE cancels it.
   always_comb begin
      ram_we    = (state == DONE) && (cmd_q == CMD_WRITE) && !data_oor;
      ram_waddr = addr_q[AW+1:2];
      ram_wdata = wdata_q;
      ram_wstrb = wstrb_q;
`ifdef AGP32_MEM_CTRL_INIT_CLEAR_EN
      if (state == INIT) begin
         ram_we    = 1'b1;
         ram_waddr = init_cnt[AW-1:0];
         ram_wdata = 32'd0;
         ram_wstrb = 4'hF;
      end
`endif
   end

   // First error wins; data range faults take priority over fetch faults.
   always_comb begin
      done_err = error;
      if (error == ERR_NONE) begin
         case (cmd_q)
            CMD_FETCH:           done_err = pc_oor ? ERR_FETCH_OOR : ERR_NONE;
            CMD_READ, CMD_WRITE: done_err = data_oor ? ERR_DATA_OOR :
                                            (pc_oor ? ERR_FETCH_OOR : ERR_NONE);
            CMD_NONE, CMD_IRQ:   done_err = ERR_NONE;
            default:             done_err = ERR_BAD_CMD;
         endcase
      end
   end

   agp32_wordram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk         (clk),
      .we          (ram_we),
      .waddr       (ram_waddr),
      .wdata       (ram_wdata),
      .wstrb       (ram_wstrb),
      .fetch_addr  (pc_q[AW+1:2]),
      .fetch_rdata (ram_fetch),
      .data_addr   (addr_q[AW+1:2]),
      .data_rdata  (ram_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= INIT;
         init_cnt        <= '0;
         lat_cnt         <= 4'd0;
         cmd_q           <= 3'd0;
         pc_q            <= 32'd0;
         addr_q          <= 32'd0;
         wdata_q         <= 32'd0;
         wstrb_q         <= 4'd0;
         ready           <= 1'b0;
         mem_start_ready <= 1'b0;
         error           <= ERR_NONE;
         inst_rdata      <= NOP_INSTR;
         data_rdata      <= 32'd0;
      end else begin
         case (state)
            INIT: begin
               if (init_cnt == CW'(INIT_LEN - 1)) begin
                  mem_start_ready <= 1'b1;
                  ready           <= 1'b1;
                  state           <= IDLE;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (command != 3'd0) begin
                  cmd_q   <= command;
                  pc_q    <= PC;
                  addr_q  <= data_addr;
                  wdata_q <= data_wdata;
                  wstrb_q <= data_wstrb;
                  lat_cnt <= 4'(LATENCY - 1);
                  ready   <= 1'b0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (lat_cnt == 4'd0) state <= DONE;
               else                 lat_cnt <= lat_cnt - 4'd1;
            end
            DONE: begin
               // RAM reads here see pre-write contents, so an aliasing fetch
               // returns the old word.
               if (cmd_q == CMD_FETCH || cmd_q == CMD_READ || cmd_q == CMD_WRITE)
                  inst_rdata <= pc_oor ? NOP_INSTR : ram_fetch;
               if (cmd_q == CMD_READ)
                  data_rdata <= data_oor ? 32'd0 : ram_data;
               else if (cmd_q == CMD_WRITE && data_oor)
                  data_rdata <= 32'd0;
               error <= done_err;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_agp32_mem_ctrl.sv
// tb/tb_agp32_mem_ctrl.sv - directed vector bench for agp32_mem_ctrl
// Honours AGP32_MEM_CTRL_INIT_CLEAR_EN for the init-length and clear checks.
module tb_agp32_mem_ctrl;

   localparam int DEPTH_WORDS = 1024;
   localparam int LATENCY     = 2;
   localparam int INIT_CYCLES = 4;
`ifdef AGP32_MEM_CTRL_INIT_CLEAR_EN
   localparam int  INIT_LEN   = DEPTH_WORDS;
   localparam bit  CLEAR_EN   = 1'b1;
`else
   localparam int  INIT_LEN   = INIT_CYCLES;
   localparam bit  CLEAR_EN   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  command = 3'd0;
   logic [31:0] PC = 32'd0;
   logic [31:0] data_addr = 32'd0;
   logic [31:0] data_wdata = 32'd0;
   logic [3:0]  data_wstrb = 4'd0;
   logic        ready;
   logic [31:0] inst_rdata;
   logic [31:0] data_rdata;
   logic        mem_start_ready;
   logic [1:0]  error;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   agp32_mem_ctrl #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .LATENCY     (LATENCY),
      .INIT_CYCLES (INIT_CYCLES)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .command         (command),
      .PC              (PC),
      .data_addr       (data_addr),
      .data_wdata      (data_wdata),
      .data_wstrb      (data_wstrb),
      .ready           (ready),
      .inst_rdata      (inst_rdata),
      .data_rdata      (data_rdata),
      .mem_start_ready (mem_start_ready),
      .error           (error)
   );

   typedef struct {
      logic [2:0]  cmd;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_inst;
      logic [31:0] exp_data;
      logic [1:0]  exp_err;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload();
      for (int i = 0; i < DEPTH_WORDS; i++) dut.u_ram.mem[i] = 32'd0;
      dut.u_ram.mem[0]    = 32'h12345678;
      dut.u_ram.mem[1]    = 32'h11112222;
      dut.u_ram.mem[4]    = 32'hDEADBEEF;
      dut.u_ram.mem[16]   = 32'hCAFEF00D;
      dut.u_ram.mem[1023] = 32'h0BADC0DE;
   endtask

   // Release happens at a negedge; INIT must last exactly INIT_LEN edges.
   task automatic wait_init(input string tag);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i < INIT_LEN; i++) @(posedge clk);
      #1;
      chk({tag, "_msr_before"}, {31'd0, mem_start_ready}, 32'd0);
      chk({tag, "_ready_before"}, {31'd0, ready}, 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_msr_after"}, {31'd0, mem_start_ready}, 32'd1);
      chk({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
   endtask

   task automatic do_cmd(input logic [2:0] cmd, input logic [31:0] pc, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb, output int lowc);
      @(negedge clk);
      command = cmd; PC = pc; data_addr = addr; data_wdata = wdata; data_wstrb = wstrb;
      @(posedge clk);
      #1;
      command = 3'd0;
      lowc = 0;
      while (!ready && lowc < 50) begin
         lowc++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int lowc;
      int rises;
      logic prev;

      vecs[0]  = '{3'd2, 32'h0,    32'h10,   32'h0,        4'h0, 32'h12345678, 32'hDEADBEEF, 2'd0};
      vecs[1]  = '{3'd1, 32'h4,    32'h0,    32'h0,        4'h0, 32'h11112222, 32'hDEADBEEF, 2'd0};
      vecs[2]  = '{3'd3, 32'h20,   32'h20,   32'hAABBCCDD, 4'h4, 32'h00000000, 32'hDEADBEEF, 2'd0};
      vecs[3]  = '{3'd2, 32'h20,   32'h20,   32'h0,        4'h0, 32'h00BB0000, 32'h00BB0000, 2'd0};
      vecs[4]  = '{3'd3, 32'h11,   32'h20,   32'h11223344, 4'h3, 32'hDEADBEEF, 32'h00BB0000, 2'd0};
      vecs[5]  = '{3'd2, 32'h0,    32'h22,   32'h0,        4'h0, 32'h12345678, 32'h00BB3344, 2'd0};
      vecs[6]  = '{3'd4, 32'h4,    32'h10,   32'h0,        4'h0, 32'h12345678, 32'h00BB3344, 2'd0};
      vecs[7]  = '{3'd2, 32'hFFC,  32'hFFC,  32'h0,        4'h0, 32'h0BADC0DE, 32'h0BADC0DE, 2'd0};
      vecs[8]  = '{3'd2, 32'h0,    32'h1000, 32'h0,        4'h0, 32'h12345678, 32'h00000000, 2'd1};
      vecs[9]  = '{3'd1, 32'h1000, 32'h0,    32'h0,        4'h0, 32'd63,       32'h00000000, 2'd1};
      vecs[10] = '{3'd3, 32'h10,   32'h2000, 32'hFFFFFFFF, 4'hF, 32'hDEADBEEF, 32'h00000000, 2'd1};
      vecs[11] = '{3'd2, 32'h10,   32'h0,    32'h0,        4'h0, 32'hDEADBEEF, 32'h12345678, 2'd1};
      vecs[12] = '{3'd7, 32'h0,    32'h0,    32'h0,        4'h0, 32'hDEADBEEF, 32'h12345678, 2'd1};

      preload();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_msr", {31'd0, mem_start_ready}, 32'd0);
      chk("rst_error", {30'd0, error}, 32'd0);
      chk("rst_inst", inst_rdata, 32'd63);
      chk("rst_data", data_rdata, 32'd0);

      wait_init("init");
      chk("init_inst", inst_rdata, 32'd63);

      if (CLEAR_EN) begin
         do_cmd(3'd2, 32'h0, 32'h40, 32'h0, 4'h0, lowc);
         chk("clear_word16", data_rdata, 32'h0);
         chk("clear_word0", inst_rdata, 32'h0);
         preload();
      end

      foreach (vecs[i]) begin
         do_cmd(vecs[i].cmd, vecs[i].pc, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lowc);
         chk($sformatf("v%0d_latency", i), 32'(lowc), 32'(LATENCY + 1));
         chk($sformatf("v%0d_inst", i), inst_rdata, vecs[i].exp_inst);
         chk($sformatf("v%0d_data", i), data_rdata, vecs[i].exp_data);
         chk($sformatf("v%0d_err", i), {30'd0, error}, {30'd0, vecs[i].exp_err});
      end

      // Second pulse lands while busy and must be dropped.
      @(negedge clk);
      command = 3'd1; PC = 32'h0;
      @(posedge clk);
      #1;
      command = 3'd0;
      @(negedge clk);
      command = 3'd1; PC = 32'h4;
      @(posedge clk);
      #1;
      command = 3'd0;
      rises = 0;
      prev = ready;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (ready && !prev) rises++;
         prev = ready;
      end
      chk("dbl_completions", 32'(rises), 32'd1);
      chk("dbl_inst", inst_rdata, 32'h12345678);

      // Reset while a write to 0x40 is in BUSY.
      @(negedge clk);
      command = 3'd3; PC = 32'h0; data_addr = 32'h40; data_wdata = 32'h0; data_wstrb = 4'hF;
      @(posedge clk);
      #1;
      command = 3'd0;
      chk("abort_busy", {31'd0, ready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_rst_ready", {31'd0, ready}, 32'd0);
      chk("abort_rst_error", {30'd0, error}, 32'd0);
      chk("abort_rst_inst", inst_rdata, 32'd63);
      repeat (2) @(posedge clk);
      wait_init("reinit");
      do_cmd(3'd2, 32'h40, 32'h40, 32'h0, 4'h0, lowc);
      chk("abort_word16", data_rdata, CLEAR_EN ? 32'h0 : 32'hCAFEF00D);

      do_cmd(3'd5, 32'h0, 32'h0, 32'h0, 4'h0, lowc);
      chk("badcmd_err", {30'd0, error}, 32'd3);
      do_cmd(3'd1, 32'h1000, 32'h0, 32'h0, 4'h0, lowc);
      chk("fetch_oor_inst", inst_rdata, 32'd63);
      chk("sticky_err", {30'd0, error}, 32'd3);
      chk("final_latency", 32'(lowc), 32'(LATENCY + 1));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
